// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with single-cycle logic/arith/compare/shift ops and an
// iterative restoring divider that takes OPER_WIDTH cycles.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   a, b       unsigned operands (OPER_WIDTH bits)
//   alu_fun    4-bit operation select
//   en         request, accepted on a rising edge when busy is low
//   busy       high while a division iterates; requests are dropped meanwhile
//   alu_out    result (OUT_WIDTH bits), held between results
//   out_valid  one-cycle pulse marking a new alu_out
//   div_err    set with out_valid on divide by zero, cleared on the next accepted request
module alu_multicycle #(
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPER_WIDTH-1:0] a,
  input  logic [OPER_WIDTH-1:0] b,
  input  logic [3:0]            alu_fun,
  input  logic                  en,
  output logic                  busy,
  output logic [OUT_WIDTH-1:0]  alu_out,
  output logic                  out_valid,
  output logic                  div_err
);

  localparam int unsigned CntW = $clog2(OPER_WIDTH + 1);
  localparam logic [3:0]  OpDiv = 4'b0011;

  typedef enum logic {StIdle, StDiv} state_e;

  state_e                state_q;
  logic [OPER_WIDTH-1:0] dvd_q;  // dividend bits shift out of the top, quotient bits in at the bottom
  logic [OPER_WIDTH-1:0] dvs_q;
  logic [OPER_WIDTH-1:0] rem_q;
  logic [CntW-1:0]       cnt_q;

  logic [OUT_WIDTH-1:0]  ae, be, res;
  logic [OPER_WIDTH:0]   rem_shift;
  logic [OPER_WIDTH-1:0] rem_sub, rem_next, quot_next;
  logic                  take;
  logic                  div_zero;

  assign ae = OUT_WIDTH'(a);
  assign be = OUT_WIDTH'(b);
  assign div_zero = (alu_fun == OpDiv) && (b == '0);

  // Single-cycle result; the divide slot only matters for the divide-by-zero case.
  always_comb begin
    res = '0;
    unique case (alu_fun)
      4'b0000: res = ae + be;
      4'b0001: res = ae - be;
      4'b0010: res = ae * be;
      4'b0011: res = '0;
      4'b0100: res = ae & be;
      4'b0101: res = ae | be;
      4'b0110: res = ~(ae & be);
      4'b0111: res = ~(ae | be);
      4'b1000: res = ae ^ be;
      4'b1001: res = ~(ae ^ be);
      4'b1010: res = (a == b) ? OUT_WIDTH'(1) : '0;
      4'b1011: res = (a > b)  ? OUT_WIDTH'(2) : '0;
      4'b1100: res = (a < b)  ? OUT_WIDTH'(3) : '0;
      4'b1101: res = ae >> 1;
      4'b1110: res = ae << 1;
      4'b1111: res = '0;
      default: res = '0;
    endcase
  end

  // One restoring step. The shifted remainder needs an extra bit; after a subtract the
  // result is below the divisor, so the low OPER_WIDTH bits of the difference are exact.
  always_comb begin
    rem_shift = {rem_q, dvd_q[OPER_WIDTH-1]};
    take      = (rem_shift >= {1'b0, dvs_q});
    rem_sub   = rem_shift[OPER_WIDTH-1:0] - dvs_q;
    rem_next  = take ? rem_sub : rem_shift[OPER_WIDTH-1:0];
    quot_next = {dvd_q[OPER_WIDTH-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      alu_out   <= '0;
      out_valid <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            if ((alu_fun == OpDiv) && !div_zero) begin
              dvd_q   <= a;
              dvs_q   <= b;
              rem_q   <= '0;
              cnt_q   <= CntW'(OPER_WIDTH);
              busy    <= 1'b1;
              div_err <= 1'b0;
              state_q <= StDiv;
            end else begin
              alu_out   <= res;
              out_valid <= 1'b1;
              div_err   <= div_zero;
            end
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          dvd_q <= quot_next;
          cnt_q <= cnt_q - CntW'(1);
          // Last iteration: counter is about to reach zero.
          if (cnt_q == CntW'(1)) begin
            alu_out   <= {rem_next, quot_next};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed scenarios followed by randomized
// operations checked against a plain-arithmetic reference model.
module tb_alu_multicycle;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  opa, opb;
  logic [3:0]    fun;
  logic          en;
  logic          busy;
  logic [OW-1:0] alu_out;
  logic          out_valid;
  logic          div_err;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  alu_multicycle #(
    .OPER_WIDTH(W),
    .OUT_WIDTH (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (opa),
    .b        (opb),
    .alu_fun  (fun),
    .en       (en),
    .busy     (busy),
    .alu_out  (alu_out),
    .out_valid(out_valid),
    .div_err  (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed directly from the operation definitions.
  function automatic logic [OW-1:0] model(input logic [3:0] op, input logic [W-1:0] x8,
                                          input logic [W-1:0] y8);
    longint unsigned x, y, r, mask;
    x    = x8;
    y    = y8;
    mask = (64'd1 << OW) - 1;
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x * y;
      4'd3:  r = (y == 0) ? 0 : (((x % y) << W) | (x / y));
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = ~(x & y);
      4'd7:  r = ~(x | y);
      4'd8:  r = x ^ y;
      4'd9:  r = ~(x ^ y);
      4'd10: r = (x == y) ? 1 : 0;
      4'd11: r = (x > y) ? 2 : 0;
      4'd12: r = (x < y) ? 3 : 0;
      4'd13: r = x >> 1;
      4'd14: r = x << 1;
      default: r = 0;
    endcase
    r = r & mask;
    return r[OW-1:0];
  endfunction

  // Issue one request with en for a single cycle, check latency, result and hold afterwards.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    logic [OW-1:0] exp;
    logic          exp_err;
    exp     = model(op, x, y);
    exp_err = (op == 4'd3) && (y == 0);
    @(negedge clk);
    fun = op; opa = x; opb = y; en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    opa = W'($urandom);
    opb = W'($urandom);
    if (op == 4'd3 && y != 0) begin
      for (int i = 0; i < W; i++) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
      end
    end
    check({tag, " result"}, 32'(alu_out), 32'(exp));
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    check({tag, " div_err"}, 32'(div_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " valid_pulse"}, 32'(out_valid), 32'd0);
    check({tag, " hold"}, 32'(alu_out), 32'(exp));
    check({tag, " err_hold"}, 32'(div_err), 32'(exp_err));
  endtask

  logic [3:0]    bb_op  [4];
  logic [W-1:0]  bb_a   [4];
  logic [W-1:0]  bb_b   [4];
  logic [OW-1:0] bb_exp [4];

  initial begin
    int unsigned   pulses;
    logic [3:0]    rop;
    logic [W-1:0]  rx, ry;

    bb_op  = '{4'd1, 4'd14, 4'd11, 4'd6};
    bb_a   = '{8'd5, 8'h81, 8'd9, 8'hF0};
    bb_b   = '{8'd6, 8'd0, 8'd3, 8'hFF};
    bb_exp = '{16'hFFFF, 16'h0102, 16'h0002, 16'hFF0F};

    rst_n = 1'b0; en = 1'b0; fun = '0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check("reset alu_out", 32'(alu_out), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset div_err", 32'(div_err), 32'd0);
    rst_n = 1'b1;

    run_op(4'd0, 8'd200, 8'd100, "add");
    check("add literal", 32'(alu_out), 32'h012C);
    run_op(4'd3, 8'd200, 8'd7, "div");
    check("div literal", 32'(alu_out), 32'h041C);
    run_op(4'd3, 8'd55, 8'd0, "div0");
    check("div0 literal", 32'(alu_out), 32'h0000);
    run_op(4'd0, 8'd1, 8'd1, "add11");
    check("add11 literal", 32'(alu_out), 32'h0002);

    // Divide with en held high and ADD presented while busy: nothing extra is accepted.
    @(negedge clk);
    fun = 4'd3; opa = 8'd255; opb = 8'd16; en = 1'b1;
    @(negedge clk);
    fun = 4'd0;
    for (int i = 0; i < W; i++) begin
      check("hold_en busy", 32'(busy), 32'd1);
      check("hold_en early_valid", 32'(out_valid), 32'd0);
      opa = W'($urandom);
      opb = W'($urandom);
      @(negedge clk);
    end
    check("hold_en result", 32'(alu_out), 32'h0F0F);
    check("hold_en valid", 32'(out_valid), 32'd1);
    check("hold_en busy_done", 32'(busy), 32'd0);
    en = 1'b0;
    @(negedge clk);
    check("hold_en no_extra", 32'(out_valid), 32'd0);
    check("hold_en hold", 32'(alu_out), 32'h0F0F);

    // Reset in the 4th busy cycle aborts the divide.
    @(negedge clk);
    fun = 4'd3; opa = 8'd100; opb = 8'd3; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort alu_out", 32'(alu_out), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort div_err", 32'(div_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort no_valid", pulses, 32'd0);
    check("abort idle_busy", 32'(busy), 32'd0);

    // Back-to-back single-cycle ops.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b result", 32'(alu_out), 32'(bb_exp[i-1]));
        check("b2b valid", 32'(out_valid), 32'd1);
      end
      if (i < 4) begin
        fun = bb_op[i]; opa = bb_a[i]; opb = bb_b[i]; en = 1'b1;
      end else begin
        en = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b valid_end", 32'(out_valid), 32'd0);

    // Randomized operations, with divide-by-zero forced occasionally.
    repeat (40) begin
      rop = 4'($urandom_range(0, 15));
      rx  = W'($urandom);
      ry  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(rop, rx, ry, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked successor to the single-cycle ALU in the register-file/system-controller datapath. All logic, bitwise, compare and shift operations complete in one cycle. Division runs as an iterative restoring divider over OPER_WIDTH cycles and returns both quotient and remainder. A BUSY output, a divide-by-zero flag and a one-cycle OUT_VALID pulse let the system controller sequence commands.

## Interface
- OPER_WIDTH, 8, operand width in bits (≥2)
- OUT_WIDTH, 2*OPER_WIDTH, result width; fixed at 2*OPER_WIDTH

- CLK  in  1  clock; single clock domain
- RST  in  1  reset; asynchronous, active-low
- A  in  OPER_WIDTH  operand A, unsigned
- B  in  OPER_WIDTH  operand B, unsigned
- ALU_FUN  in  4  operation select
- EN  in  1  request; accepted on a rising CLK edge when EN=1 and BUSY=0
- BUSY  out  1  high while a division is iterating; requests are ignored
- ALU_OUT  out  OUT_WIDTH  result; holds its value between results
- OUT_VALID  out  1  one-cycle pulse marking a new ALU_OUT
- DIV_ERR  out  1  set with OUT_VALID when the divisor is zero; cleared on the next accepted request

## Operation
- Reset state: ALU_OUT=0, OUT_VALID=0, BUSY=0, DIV_ERR=0, FSM=IDLE, internal divider registers cleared.
- Operands are zero-extended to OUT_WIDTH. Results wrap modulo 2^OUT_WIDTH.
- Opcodes:
  - 0000 A+B
  - 0001 A-B (two's-complement wrap)
  - 0010 A*B
  - 0011 divide
  - 0100 AND
  - 0101 OR
  - 0110 NAND
  - 0111 NOR
  - 1000 XOR
  - 1001 XNOR
  - 1010 result 1 if A==B, else 0
  - 1011 result 2 if A>B, else 0
  - 1100 result 3 if A<B, else 0
  - 1101 A>>1
  - 1110 A<<1
  - 1111 result 0
- Bitwise inversions apply to the full OUT_WIDTH, so the upper half of the result is all ones.
- Divide result: ALU_OUT[OPER_WIDTH-1:0]=quotient, ALU_OUT[OUT_WIDTH-1:OPER_WIDTH]=remainder.
- FSM states: IDLE and DIV.
  - IDLE, request accepted, op≠0011, or op=0011 with B=0: register the result, pulse OUT_VALID, stay in IDLE.
  - If B=0 on a divide: ALU_OUT=0, DIV_ERR=1.
  - IDLE, request accepted, op=0011, B≠0: latch A and B, clear the partial remainder, load the iteration counter with OPER_WIDTH, set BUSY, go to DIV.
  - DIV: each cycle, shift {rem, quot} left by one and bring in the next dividend MSB; subtract the divisor when the partial remainder ≥ divisor and set the quotient LSB. Decrement the counter.
  - DIV, counter reaches 0: write ALU_OUT, pulse OUT_VALID, clear BUSY, return to IDLE.
- EN while BUSY=1 is ignored and dropped, not queued. A and B may change freely during DIV.
- EN=0 in IDLE: OUT_VALID=0, ALU_OUT and DIV_ERR hold.
- Reset asserted mid-division: division is aborted immediately to the reset state. No OUT_VALID is produced.

## Timing
- Single-cycle ops: request sampled at edge N; ALU_OUT valid and OUT_VALID=1 after edge N, for one cycle.
- Back-to-back single-cycle requests give one result per cycle; OUT_VALID stays high continuously.
- Divide: request sampled at edge N. BUSY=1 from after edge N until edge N+OPER_WIDTH. At edge N+OPER_WIDTH: OUT_VALID=1, BUSY=0.
- Total divide latency is OPER_WIDTH cycles. A new request can be accepted at edge N+OPER_WIDTH+1 or later.
- Divide by zero: single-cycle latency; BUSY never asserted.

## Test plan
- Reset, then ADD A=200 B=100, width 8 → ALU_OUT=0x012C, OUT_VALID high one cycle, BUSY=0.
- DIV A=200 B=7 → BUSY high 8 cycles, then ALU_OUT=0x041C (remainder 4, quotient 28), OUT_VALID pulse, DIV_ERR=0.
- DIV A=55 B=0 → next cycle ALU_OUT=0x0000, DIV_ERR=1, OUT_VALID=1, BUSY=0. Then ADD 1+1 → ALU_OUT=0x0002, DIV_ERR=0.
- DIV A=255 B=16, with EN held high and opcode ADD applied during BUSY → only one result, 0x0F0F; no extra OUT_VALID.
- DIV A=100 B=3, RST pulsed low at the 4th busy cycle → all outputs 0 immediately; no OUT_VALID after reset release.
- Back-to-back sequence SUB 5-6, SHL A=0x81, GT 9>3, NAND 0xF0&0xFF → 0xFFFF, 0x0102, 0x0002, 0xFF0F on consecutive cycles, with OUT_VALID high for 4 cycles.
